// File: rtl/map_state_ram.sv
// Live playfield tile map: copies a level background ROM into local storage on request,
// then serves registered renderer reads and game-logic tile rewrites while tracking free cells.
module map_state_ram #(
  parameter int MAP_W = 20,
  parameter int MAP_H = 15,
  parameter int AW    = 9,
  parameter int DW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_q,
  output logic          busy,
  output logic          done,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  input  logic          upd_en,
  input  logic [AW-1:0] upd_addr,
  input  logic [DW-1:0] upd_data,
  output logic [AW-1:0] free_count
);

  localparam int            N      = MAP_W * MAP_H;
  localparam logic [AW-1:0] N_A    = AW'(N);
  localparam logic [AW-1:0] LAST_A = AW'(N - 1);

  typedef enum logic {IDLE, COPY} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt;
  logic [DW-1:0] mem [N];
  logic          last_cell;
  logic          upd_ok;
  logic          rd_in_range;
  logic [DW-1:0] old_tile;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (load) state_nxt = COPY;
      COPY: if (last_cell) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy        = (state == COPY);
  assign rom_addr    = busy ? cnt : '0;
  assign last_cell   = (cnt == LAST_A);
  assign upd_ok      = !busy && upd_en && (upd_addr < N_A);
  assign rd_in_range = (rd_addr < N_A);
  // The old tile is only consumed when upd_ok guarantees the address is in range.
  assign old_tile    = (upd_addr < N_A) ? mem[upd_addr] : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      done       <= 1'b0;
      free_count <= '0;
    end else begin
      state <= state_nxt;
      done  <= busy && last_cell;
      if (state == IDLE && load) begin
        cnt        <= '0;
        free_count <= '0;
      end else if (busy) begin
        cnt <= cnt + AW'(1);
        if (rom_q == '0) free_count <= free_count + AW'(1);
      end else if (upd_ok) begin
        if (old_tile == '0 && upd_data != '0)      free_count <= free_count - AW'(1);
        else if (old_tile != '0 && upd_data == '0) free_count <= free_count + AW'(1);
      end
    end
  end

  // NOTE: the tile array has no reset so it maps onto plain RAM; it is valid only after a load.
  always_ff @(posedge clk) begin
    if (busy)        mem[cnt]      <= rom_q;
    else if (upd_ok) mem[upd_addr] <= upd_data;
  end

  // Read-before-write: a same-edge update is seen by the following read.
  always_ff @(posedge clk) begin
    if (rst)              rd_data <= '0;
    else if (rd_in_range) rd_data <= mem[rd_addr];
    else                  rd_data <= '0;
  end

endmodule
